// File: rtl/lcd_ctrl.sv
// HD44780 character LCD sequencer: power-up wait, init command ROM, then
// single-byte command/data writes over valid/ready with full bus timing.
module lcd_ctrl #(
  parameter int unsigned T_PWRUP = 405000,
  parameter int unsigned T_SETUP = 2,
  parameter int unsigned T_EN    = 12,
  parameter int unsigned T_HOLD  = 2,
  parameter int unsigned T_CMD   = 1080,
  parameter int unsigned T_CLEAR = 44280,
  parameter int unsigned CNT_W   = 20
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       req_valid_i,
  output logic       req_ready_o,
  input  logic       req_rs_i,
  input  logic [7:0] req_data_i,
  output logic       busy_o,
  output logic       init_done_o,
  output logic       lcd_on_o,
  output logic       lcd_en_o,
  output logic       lcd_rs_o,
  output logic       lcd_rw_o,
  output logic [7:0] lcd_data_o
);

  typedef enum logic [2:0] {
    PWRUP, LOAD, SETUP, PULSE, HOLD, WAIT, IDLE
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d, limit;
  logic [1:0]       idx_q, idx_d;
  logic             en_q, en_d;
  logic             rs_q, rs_d;
  logic [7:0]       data_q, data_d;
  logic             on_q, on_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [7:0]       rom_byte;
  logic             is_clear;
  logic             phase_end;

  always_comb begin
    rom_byte = 8'h38;
    case (idx_q)
      2'd0: rom_byte = 8'h38;
      2'd1: rom_byte = 8'h0C;
      2'd2: rom_byte = 8'h01;
      2'd3: rom_byte = 8'h06;
      default: rom_byte = 8'h38;
    endcase
  end

  // Clear/home commands need the long settle time; data bytes never do.
  assign is_clear = !rs_q && (data_q == 8'h01 || data_q == 8'h02 || data_q == 8'h03);

  always_comb begin
    limit = '0;
    case (state_q)
      PWRUP:   limit = CNT_W'(T_PWRUP - 1);
      SETUP:   limit = CNT_W'(T_SETUP - 1);
      PULSE:   limit = CNT_W'(T_EN - 1);
      HOLD:    limit = CNT_W'(T_HOLD - 1);
      WAIT:    limit = is_clear ? CNT_W'(T_CLEAR - 1) : CNT_W'(T_CMD - 1);
      default: limit = '0;
    endcase
  end

  assign phase_end = (timer_q == limit);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    rs_d    = rs_q;
    data_d  = data_q;
    done_d  = done_q;
    case (state_q)
      PWRUP: if (phase_end) state_d = LOAD;
      LOAD: begin
        state_d = SETUP;
        rs_d    = 1'b0;
        data_d  = rom_byte;
      end
      SETUP: if (phase_end) state_d = PULSE;
      PULSE: if (phase_end) state_d = HOLD;
      HOLD:  if (phase_end) state_d = WAIT;
      WAIT: begin
        if (phase_end) begin
          if (done_q) begin
            state_d = IDLE;
          end else if (idx_q == 2'd3) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            idx_d   = idx_q + 2'd1;
            state_d = LOAD;
          end
        end
      end
      IDLE: begin
        if (req_valid_i && ready_q) begin
          state_d = SETUP;
          rs_d    = req_rs_i;
          data_d  = req_data_i;
        end
      end
      default: state_d = PWRUP;
    endcase

    timer_d = (state_d != state_q || state_q == IDLE) ? '0 : timer_q + CNT_W'(1);
    // Outputs are derived from the next state so they register alongside it.
    en_d    = (state_d == PULSE);
    ready_d = (state_d == IDLE);
    busy_d  = (state_d != IDLE);
    on_d    = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= PWRUP;
      timer_q <= '0;
      idx_q   <= '0;
      en_q    <= 1'b0;
      rs_q    <= 1'b0;
      data_q  <= '0;
      on_q    <= 1'b0;
      ready_q <= 1'b0;
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      idx_q   <= idx_d;
      en_q    <= en_d;
      rs_q    <= rs_d;
      data_q  <= data_d;
      on_q    <= on_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign req_ready_o = ready_q;
  assign busy_o      = busy_q;
  assign init_done_o = done_q;
  assign lcd_on_o    = on_q;
  assign lcd_en_o    = en_q;
  assign lcd_rs_o    = rs_q;
  assign lcd_rw_o    = 1'b0;
  assign lcd_data_o  = data_q;

endmodule
